// File: rtl/rv32i_pkg.sv
// Shared RV32I SoC definitions used by the PSRAM arbiter.
//   psram_arb_state_t : word-access sequencer states (two 16-bit halves per word)
//   psram_arb_port_t  : requester identity (instruction fetch or data port)
//   PSRAM_BANK_BIT    : requester byte-address bit that selects the PSRAM bank
package rv32i;

    localparam int PSRAM_BANK_BIT = 23;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_LO,
        WAIT_LO,
        ISSUE_HI,
        WAIT_HI,
        DONE
    } psram_arb_state_t;

    typedef enum logic {
        ARB_IFETCH = 1'b0,
        ARB_DATA   = 1'b1
    } psram_arb_port_t;

endpackage

// File: rtl/psram_arb_rr.sv
// Two-way round-robin picker, purely combinational.
// Ports:
//   req[1:0] in  : pending requests, bit 0 = fetch port, bit 1 = data port
//   last     in  : port that was granted most recently
//   grant    out : winning port (only meaningful while valid=1)
//   valid    out : at least one request is pending
module psram_arb_rr
    import rv32i::*;
(
    input  logic [1:0]      req,
    input  psram_arb_port_t last,
    output psram_arb_port_t grant,
    output logic            valid
);

    // A lone request wins outright; a tie goes to the port not served last.
    always_comb begin
        valid = |req;
        grant = ARB_IFETCH;
        if (req == 2'b11) begin
            grant = (last == ARB_IFETCH) ? ARB_DATA : ARB_IFETCH;
        end else if (req[1]) begin
            grant = ARB_DATA;
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// Shares one 16-bit PSRAM controller between the RV32I fetch and data ports.
// Every 32-bit access becomes two PSRAM transactions, low half first, and the
// two halves are never interleaved with the other port's traffic.
// All outputs are registered.
//
// Optional feature macro: PSRAM_ARBITER_HALF_SKIP_EN
//   defined   : write halves whose two strobes are both 0 are not issued
//   undefined : both halves are always issued (zero strobes -> no bytes written)
//
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   i_req/i_addr                : fetch request, held until i_ack
//   i_rdata/i_ack               : fetch data with one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata/d_wstrb : data request, held until d_ack
//   d_rdata/d_ack               : read data with one-cycle completion pulse
//   p_bank_sel/p_addr/p_write_en/p_read_en/p_data_in/
//   p_write_high_byte/p_write_low_byte : command side to the psram controller
//   p_read_avail/p_data_out/p_busy     : response side from the psram controller
module psram_arbiter
    import rv32i::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              p_bank_sel,
    output logic [21:0]       p_addr,
    output logic              p_write_en,
    output logic              p_read_en,
    output logic [15:0]       p_data_in,
    output logic              p_write_high_byte,
    output logic              p_write_low_byte,
    input  logic              p_read_avail,
    input  logic [15:0]       p_data_out,
    input  logic              p_busy
);

    psram_arb_state_t state, state_n;
    psram_arb_port_t  last, last_n;
    psram_arb_port_t  cur_port, port_n;
    psram_arb_port_t  pick;
    logic             pick_valid;

    logic             cur_we, we_n;
    logic             cur_bank, bank_n;
    logic [20:0]      cur_idx, idx_n;
    logic [31:0]      cur_wdata, wdata_n;
    logic [3:0]       cur_wstrb, wstrb_n;
    logic [15:0]      rdata_lo, rdata_lo_n;
    logic             read_capture;

    logic [31:0]      i_rdata_n, d_rdata_n;
    logic             i_ack_n, d_ack_n;
    logic             p_bank_sel_n, p_write_en_n, p_read_en_n;
    logic [21:0]      p_addr_n;
    logic [15:0]      p_data_in_n;
    logic             p_hb_n, p_lb_n;
    logic             half;

    // The two low address bits are ignored: every access is word-aligned.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    psram_arb_rr u_rr (
        .req   ({d_req, i_req}),
        .last  (last),
        .grant (pick),
        .valid (pick_valid)
    );

    // A read half completes in the first WAIT cycle that sees the psram idle.
    assign read_capture = ((state == WAIT_LO) || (state == WAIT_HI)) && !p_busy && !cur_we;

    // Sequencer: next state, latched request fields and the next values of
    // every registered output. Outputs are derived from the state being
    // entered so that they line up with that state without a combinational path.
    always_comb begin
        state_n    = state;
        last_n     = last;
        port_n     = cur_port;
        we_n       = cur_we;
        bank_n     = cur_bank;
        idx_n      = cur_idx;
        wdata_n    = cur_wdata;
        wstrb_n    = cur_wstrb;
        rdata_lo_n = rdata_lo;

        unique case (state)
            IDLE: begin
                // Never start while the psram is still finishing earlier work,
                // which includes a transaction cut off by our own reset.
                if (!p_busy && pick_valid) begin
                    port_n = pick;
                    if (pick == ARB_DATA) begin
                        we_n    = d_we;
                        bank_n  = d_addr[PSRAM_BANK_BIT];
                        idx_n   = d_addr[PSRAM_BANK_BIT-1:2];
                        wdata_n = d_wdata;
                        wstrb_n = d_wstrb;
                    end else begin
                        we_n    = 1'b0;
                        bank_n  = i_addr[PSRAM_BANK_BIT];
                        idx_n   = i_addr[PSRAM_BANK_BIT-1:2];
                        wdata_n = '0;
                        wstrb_n = '0;
                    end
                    state_n = ISSUE_LO;
`ifdef PSRAM_ARBITER_HALF_SKIP_EN
                    if (we_n && (wstrb_n[1:0] == 2'b00)) begin
                        state_n = (wstrb_n[3:2] == 2'b00) ? DONE : ISSUE_HI;
                    end
`endif
                end
            end
            ISSUE_LO: state_n = WAIT_LO;
            WAIT_LO: begin
                if (!p_busy) begin
                    if (read_capture) begin
                        rdata_lo_n = p_data_out;
                    end
                    state_n = ISSUE_HI;
`ifdef PSRAM_ARBITER_HALF_SKIP_EN
                    if (cur_we && (cur_wstrb[3:2] == 2'b00)) begin
                        state_n = DONE;
                    end
`endif
                end
            end
            ISSUE_HI: state_n = WAIT_HI;
            WAIT_HI: begin
                if (!p_busy) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                last_n  = cur_port;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        i_rdata_n    = '0;
        d_rdata_n    = '0;
        i_ack_n      = 1'b0;
        d_ack_n      = 1'b0;
        p_bank_sel_n = 1'b0;
        p_addr_n     = '0;
        p_write_en_n = 1'b0;
        p_read_en_n  = 1'b0;
        p_data_in_n  = '0;
        p_hb_n       = 1'b0;
        p_lb_n       = 1'b0;
        half         = (state_n == ISSUE_HI);

        if ((state_n == ISSUE_LO) || (state_n == ISSUE_HI)) begin
            p_bank_sel_n = bank_n;
            p_addr_n     = {idx_n, half};
            p_read_en_n  = !we_n;
            p_write_en_n = we_n;
            if (we_n) begin
                p_data_in_n = half ? wdata_n[31:16] : wdata_n[15:0];
                p_hb_n      = half ? wstrb_n[3] : wstrb_n[1];
                p_lb_n      = half ? wstrb_n[2] : wstrb_n[0];
            end
        end

        // The high half arrives on p_data_out in the cycle that enters DONE.
        if (state_n == DONE) begin
            if (port_n == ARB_IFETCH) begin
                i_ack_n   = 1'b1;
                i_rdata_n = {p_data_out, rdata_lo_n};
            end else begin
                d_ack_n   = 1'b1;
                d_rdata_n = we_n ? 32'h0 : {p_data_out, rdata_lo_n};
            end
        end
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            last              <= ARB_DATA;
            cur_port          <= ARB_IFETCH;
            cur_we            <= 1'b0;
            cur_bank          <= 1'b0;
            cur_idx           <= '0;
            cur_wdata         <= '0;
            cur_wstrb         <= '0;
            rdata_lo          <= '0;
            i_rdata           <= '0;
            i_ack             <= 1'b0;
            d_rdata           <= '0;
            d_ack             <= 1'b0;
            p_bank_sel        <= 1'b0;
            p_addr            <= '0;
            p_write_en        <= 1'b0;
            p_read_en         <= 1'b0;
            p_data_in         <= '0;
            p_write_high_byte <= 1'b0;
            p_write_low_byte  <= 1'b0;
        end else begin
            state             <= state_n;
            last              <= last_n;
            cur_port          <= port_n;
            cur_we            <= we_n;
            cur_bank          <= bank_n;
            cur_idx           <= idx_n;
            cur_wdata         <= wdata_n;
            cur_wstrb         <= wstrb_n;
            rdata_lo          <= rdata_lo_n;
            i_rdata           <= i_rdata_n;
            i_ack             <= i_ack_n;
            d_rdata           <= d_rdata_n;
            d_ack             <= d_ack_n;
            p_bank_sel        <= p_bank_sel_n;
            p_addr            <= p_addr_n;
            p_write_en        <= p_write_en_n;
            p_read_en         <= p_read_en_n;
            p_data_in         <= p_data_in_n;
            p_write_high_byte <= p_hb_n;
            p_write_low_byte  <= p_lb_n;
        end
    end

`ifndef SYNTHESIS
    read_avail_on_capture: assert property (@(posedge clk) disable iff (!rst_n)
        read_capture |-> p_read_avail);
`endif

endmodule
